systolic_mm_engine: RTL

- Parametrised, self-sequencing output-stationary systolic matrix multiplier. Computes C[N×N] = A[N×K] · B[K×N], with K chosen at run time.
- Generalises the fixed 16×16 tiled array: N, data width, accumulator width and signedness are all parameters.
- Adds what the fixed array lacks: input skew, a start/done command interface, a valid/ready operand stream, flush control and backpressured row-by-row result drain.
- Sits between the operand buffers and the result writeback path in the accelerator datapath.

---
 rtl/systolic_pkg.sv | 26 ++
 rtl/systolic_mm_engine_pe.sv | 49 ++++
 rtl/systolic_mm_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix engine.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_e;

  localparam int unsigned EXT_W = 128;

  function automatic int unsigned kw(input int unsigned k_max);
    return $clog2(k_max + 1);
  endfunction

  function automatic int unsigned rw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Sign- or zero-extends a pw-bit product held in the low bits of p.
  function automatic logic [EXT_W-1:0] ext_prod(input logic [EXT_W-1:0] p,
                                                input int unsigned pw,
                                                input logic sgn);
    logic [EXT_W-1:0] hi;
    hi = {EXT_W{1'b1}} << pw;
    if (sgn && p[7'(pw - 1)]) return p | hi;
    return p & ~hi;
  endfunction

endpackage

// File: rtl/systolic_mm_engine_pe.sv
// Single MAC cell: forwards a east and b south, accumulates a*b every cycle.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  localparam int unsigned PW = 2 * DATA_W;

  logic [PW-1:0]    a_x, b_x, prod_c;
  logic [ACC_W-1:0] prod_ext_c;

  // Operands are pre-extended to PW so one unsigned multiply serves both modes.
  always_comb begin
    if (SIGNED != 0) begin
      a_x = {{DATA_W{a_in[DATA_W-1]}}, a_in};
      b_x = {{DATA_W{b_in[DATA_W-1]}}, b_in};
    end else begin
      a_x = {{DATA_W{1'b0}}, a_in};
      b_x = {{DATA_W{1'b0}}, b_in};
    end
    prod_c     = a_x * b_x;
    prod_ext_c = ACC_W'(ext_prod(EXT_W'(prod_c), PW, SIGNED != 0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + prod_ext_c;
    end
  end

endmodule

// File: rtl/systolic_mm_engine.sv
// Self-sequencing N x N output-stationary systolic multiplier: C = A * B with runtime K.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned K_MAX  = 1024,
  parameter int unsigned SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [kw(K_MAX)-1:0]     k_len,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*DATA_W-1:0]      a_col,
  input  logic [N*DATA_W-1:0]      b_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [rw(N)-1:0]         out_row_idx,
  output logic [N*ACC_W-1:0]       out_row,
  output logic                     done
);

  localparam int unsigned KW = kw(K_MAX);
  localparam int unsigned RW = rw(N);
  localparam int unsigned FW = $clog2(2 * N);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d, beat_q, beat_d;
  logic [FW-1:0]     flush_q, flush_d;
  logic [RW-1:0]     idx_d;
  logic              out_valid_d, done_d;
  logic              accept_c, clr_c, load_row_c, zero_row_c;
  logic [N*ACC_W-1:0] row_mux_c, row_d;

  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];
  logic [DATA_W-1:0] a_h [N][N+1];
  logic [DATA_W-1:0] b_v [N+1][N];
  logic [ACC_W-1:0]  acc [N][N];

  assign accept_c = in_ready & in_valid;

  // Input skew: lane i is delayed i cycles; idle cycles inject zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_W-1:0] a_src, b_src;
    assign a_src = accept_c ? a_col[i*DATA_W +: DATA_W] : '0;
    assign b_src = accept_c ? b_row[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_src;
      assign b_edge[i] = b_src;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sr [i];
      logic [DATA_W-1:0] b_sr [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_src;
          b_sr[0] <= b_src;
          for (int s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_edge[i] = a_sr[i-1];
      assign b_edge[i] = b_sr[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    assign a_h[i][0] = a_edge[i];
    assign b_v[0][i] = b_edge[i];
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_c),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc[i][j])
      );
    end
  end

  always_comb begin
    row_mux_c = '0;
    for (int j = 0; j < N; j++) row_mux_c[j*ACC_W +: ACC_W] = acc[idx_d][j];
  end

  always_comb begin
    row_d = out_row;
    if (zero_row_c)      row_d = '0;
    else if (load_row_c) row_d = row_mux_c;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_d      = beat_q;
    flush_d     = flush_q;
    idx_d       = out_row_idx;
    out_valid_d = out_valid;
    done_d      = 1'b0;
    clr_c       = 1'b0;
    load_row_c  = 1'b0;
    zero_row_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d    = k_len;
          beat_d = '0;
          idx_d  = '0;
          clr_c  = 1'b1;
          if (k_len != '0) begin
            state_d = LOAD;
          end else begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            zero_row_c  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept_c) begin
          beat_d = beat_q + 1'b1;
          if (KW'(beat_q + 1'b1) == k_q) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
      end
      FLUSH: begin
        if (flush_q == FW'(2 * N - 2)) begin
          state_d     = DRAIN;
          out_valid_d = 1'b1;
          idx_d       = '0;
          load_row_c  = 1'b1;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (out_row_idx == RW'(N - 1)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            idx_d       = '0;
            zero_row_c  = 1'b1;
          end else begin
            idx_d      = out_row_idx + 1'b1;
            load_row_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      beat_q      <= '0;
      flush_q     <= '0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      out_row     <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_q      <= beat_d;
      flush_q     <= flush_d;
      busy        <= (state_d != IDLE);
      in_ready    <= (state_d == LOAD);
      out_valid   <= out_valid_d;
      out_row_idx <= idx_d;
      out_row     <= row_d;
      done        <= done_d;
    end
  end

endmodule
